// File: rtl/alu_sequencer.sv
// Multi-cycle MUL/DIVU/REMU sequencer driving a shared external ALU.
// Define ALU_SEQ_DIV_EN to build the restoring divider (DIVU/REMU); otherwise those ops finish at once with result 0.
module alu_sequencer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] opa,
   input  logic [31:0] opb,
   input  logic        flush,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [2:0]  alu_sel,
   input  logic [31:0] alu_result
);

   localparam logic [2:0] SEL_ADD  = 3'b000;
   localparam logic [2:0] SEL_SUB  = 3'b001;
   localparam logic [2:0] SEL_SLTU = 3'b101;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MUL,
`ifdef ALU_SEQ_DIV_EN
      S_DCMP,
      S_DSUB,
`endif
      S_DONE
   } state_t;

   state_t      state_q;
   logic        busy_q;
   logic        done_q;
   logic [31:0] result_q;
   logic [31:0] acc_q;
   logic [31:0] mcand_q;
   logic [31:0] mplier_q;
   logic [4:0]  cnt_q;
   logic [31:0] acc_d;

   assign acc_d = mplier_q[0] ? alu_result : acc_q;

`ifdef ALU_SEQ_DIV_EN
   logic [31:0] dividend_q;
   logic [31:0] divisor_q;
   logic [31:0] rem_q;
   logic [31:0] quot_q;
   logic        qbit_q;
   logic        rem_sel_q;
   logic [31:0] rem_shift;
   logic [31:0] rem_d;
   logic [31:0] quot_d;

   // rem_q[31] acts as the hidden 33rd bit: when set, the shifted remainder always exceeds the divisor.
   assign rem_shift = {rem_q[30:0], dividend_q[31]};
   assign rem_d     = qbit_q ? alu_result : rem_shift;
   assign quot_d    = {quot_q[30:0], qbit_q};
`else
   logic op_unused;
   assign op_unused = op[0];
`endif

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;

   always_comb begin
      alu_a   = '0;
      alu_b   = '0;
      alu_sel = SEL_ADD;
      case (state_q)
         S_MUL: begin
            alu_a = acc_q;
            alu_b = mcand_q;
         end
`ifdef ALU_SEQ_DIV_EN
         S_DCMP: begin
            alu_a   = rem_shift;
            alu_b   = divisor_q;
            alu_sel = SEL_SLTU;
         end
         S_DSUB: begin
            alu_a   = rem_shift;
            alu_b   = divisor_q;
            alu_sel = SEL_SUB;
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         result_q   <= '0;
         acc_q      <= '0;
         mcand_q    <= '0;
         mplier_q   <= '0;
         cnt_q      <= '0;
`ifdef ALU_SEQ_DIV_EN
         dividend_q <= '0;
         divisor_q  <= '0;
         rem_q      <= '0;
         quot_q     <= '0;
         qbit_q     <= 1'b0;
         rem_sel_q  <= 1'b0;
`endif
      end else if (flush) begin
         state_q <= S_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               done_q  <= 1'b0;
               state_q <= S_IDLE;
               if (start) begin
                  acc_q    <= '0;
                  mcand_q  <= opa;
                  mplier_q <= opb;
                  cnt_q    <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= S_MUL;
`ifdef ALU_SEQ_DIV_EN
                  dividend_q <= opa;
                  divisor_q  <= opb;
                  rem_q      <= '0;
                  quot_q     <= '0;
                  rem_sel_q  <= op[0];
                  if (op[1]) state_q <= S_DCMP;
`else
                  if (op[1]) begin
                     busy_q   <= 1'b0;
                     done_q   <= 1'b1;
                     result_q <= '0;
                     state_q  <= S_DONE;
                  end
`endif
               end
            end
            S_MUL: begin
               acc_q    <= acc_d;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + 5'd1;
               if (cnt_q == 5'd31) begin
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  result_q <= acc_d;
                  state_q  <= S_DONE;
               end
            end
`ifdef ALU_SEQ_DIV_EN
            S_DCMP: begin
               qbit_q  <= rem_q[31] | ~alu_result[0];
               state_q <= S_DSUB;
            end
            S_DSUB: begin
               rem_q      <= rem_d;
               quot_q     <= quot_d;
               dividend_q <= dividend_q << 1;
               cnt_q      <= cnt_q + 5'd1;
               state_q    <= S_DCMP;
               if (cnt_q == 5'd31) begin
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  result_q <= rem_sel_q ? rem_d : quot_d;
                  state_q  <= S_DONE;
               end
            end
`endif
            default: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: spec vectors, corner sequences and randomized ops vs an arithmetic model.
`timescale 1ns/1ps
module tb_alu_sequencer;
`ifdef ALU_SEQ_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic        flush = 1'b0;
   logic [1:0]  op = '0;
   logic [31:0] opa = '0;
   logic [31:0] opb = '0;
   logic        busy, done;
   logic [31:0] result, alu_a, alu_b, alu_result;
   logic [2:0]  alu_sel;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      string       name;
   } vec_t;

   vec_t vecs[9];

   alu_sequencer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .opa(opa), .opb(opb),
      .flush(flush), .busy(busy), .done(done), .result(result),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result)
   );

   always #5 clk = ~clk;

   // Shared ALU seen by the sequencer
   always_comb begin
      case (alu_sel)
         3'b000:  alu_result = alu_a + alu_b;
         3'b001:  alu_result = alu_a - alu_b;
         3'b101:  alu_result = {31'd0, (alu_a < alu_b)};
         default: alu_result = '0;
      endcase
   end

   function automatic logic [31:0] model_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      if (!o[1]) begin
         p = 64'(a) * 64'(b);
         return p[31:0];
      end
      if (!DIV_EN) return 32'd0;
      if (!o[0]) return (b == 0) ? 32'hFFFF_FFFF : a / b;
      return (b == 0) ? a : a % b;
   endfunction

   function automatic int model_lat(input logic [1:0] o);
      if (!o[1]) return 33;
      return DIV_EN ? 65 : 1;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
      end
   endtask

   // Called right after a falling edge; returns at the falling edge of the done cycle.
   task automatic do_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
      int lat, bad_busy, bad_sel;
      logic [2:0] want_sel;
      lat = model_lat(o);
      bad_busy = 0;
      bad_sel = 0;
      start = 1'b1; op = o; opa = a; opb = b;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; op = 2'($urandom); opa = $urandom; opb = $urandom;
      for (int cyc = 1; cyc < lat; cyc++) begin
         if (busy !== 1'b1 || done !== 1'b0) bad_busy++;
         if (!o[1]) want_sel = 3'b000;
         else want_sel = (cyc % 2 == 1) ? 3'b101 : 3'b001;
         if (alu_sel !== want_sel) bad_sel++;
         @(negedge clk);
      end
      if (lat > 1) begin
         check({name, "_busy_window_bad_cycles"}, 32'(bad_busy), 32'd0);
         check({name, "_alu_sel_bad_cycles"}, 32'(bad_sel), 32'd0);
      end
      check({name, "_done"}, 32'(done), 32'd1);
      check({name, "_busy_in_done"}, 32'(busy), 32'd0);
      check({name, "_result"}, result, exp);
      check({name, "_alu_idle_or"}, alu_a | alu_b | 32'(alu_sel), 32'd0);
   endtask

   task automatic gap(input string name);
      @(negedge clk);
      check({name, "_done_pulse_end"}, 32'(done), 32'd0);
      check({name, "_idle_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] last_res, a, b;
      logic [1:0]  o;
      int          bad;

      vecs[0] = '{2'b00, 32'd7, 32'd6, 32'd42, "mul_7x6"};
      vecs[1] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "mul_ff_ff"};
      vecs[2] = '{2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, "mul_rsv_wrap"};
      vecs[3] = '{2'b10, 32'd100, 32'd7, DIV_EN ? 32'd14 : 32'd0, "divu_100_7"};
      vecs[4] = '{2'b11, 32'd100, 32'd7, DIV_EN ? 32'd2 : 32'd0, "remu_100_7"};
      vecs[5] = '{2'b10, 32'h8000_0000, 32'd3, DIV_EN ? 32'h2AAA_AAAA : 32'd0, "divu_big_3"};
      vecs[6] = '{2'b11, 32'hFFFF_FFFF, 32'h8000_0001, DIV_EN ? 32'h7FFF_FFFE : 32'd0, "remu_msb"};
      vecs[7] = '{2'b10, 32'h0000_1234, 32'd0, DIV_EN ? 32'hFFFF_FFFF : 32'd0, "divu_by0"};
      vecs[8] = '{2'b11, 32'h0000_1234, 32'd0, DIV_EN ? 32'h0000_1234 : 32'd0, "remu_by0"};

      #1 rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_alu_or", alu_a | alu_b | 32'(alu_sel), 32'd0);

      // First rising edge after release must already accept start
      rst_n = 1'b1;
      for (int i = 0; i < 9; i++) begin
         do_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
         gap(vecs[i].name);
      end

      // Start during the done cycle is accepted
      do_op("b2b_first", 2'b00, 32'd3, 32'd5, 32'd15);
      do_op("b2b_second", 2'b00, 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF);
      gap("b2b");
      last_res = 32'hFFFF_FFFF;

      // Flush during cycle 10 of a multiply
      start = 1'b1; op = 2'b00; opa = 32'd9; opb = 32'd9;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_busy", 32'(busy), 32'd0);
      check("flush_done", 32'(done), 32'd0);
      check("flush_result_kept", result, last_res);
      bad = 0;
      repeat (40) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) bad++;
      end
      check("flush_no_late_done", 32'(bad), 32'd0);

      // Flush outranks start
      start = 1'b1; flush = 1'b1; op = 2'b00; opa = 32'd2; opb = 32'd2;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      check("flush_over_start_busy", 32'(busy), 32'd0);

      // Asynchronous reset at cycle 20 of a long operation
      start = 1'b1; op = DIV_EN ? 2'b10 : 2'b00; opa = 32'd100; opb = 32'd7;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(negedge clk);
      check("pre_rst_busy", 32'(busy), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_result", result, 32'd0);
      check("midrst_alu_or", alu_a | alu_b | 32'(alu_sel), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      repeat (80) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) bad++;
      end
      check("midrst_no_done", 32'(bad), 32'd0);

      // Randomized operations against the arithmetic model
      for (int i = 0; i < 30; i++) begin
         o = 2'($urandom_range(0, 3));
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: b = 32'($urandom_range(1, 15));
            2: a = 32'hFFFF_FFFF;
            default: ;
         endcase
         do_op($sformatf("rnd%0d", i), o, a, b, model_res(o, a, b));
         gap($sformatf("rnd%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have port clk  input  1  single clock, rising-edge active.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port start  input  1  request new operation; sampled only when busy=0.
REQ-004 SHALL have port op  input  2  00 MUL (low 32), 01 reserved (treated as MUL), 10 DIVU, 11 REMU.
REQ-005 SHALL have port opa  input  32  multiplicand / dividend, captured with start.
REQ-006 SHALL have port opb  input  32  multiplier / divisor, captured with start.
REQ-007 SHALL have port flush  input  1  abort current operation.
REQ-008 SHALL have port busy  output  1  operation in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-010 SHALL have port result  output  32  last completed result, held until next done.
REQ-011 SHALL have ports alu_a, alu_b  output  32 each, alu_sel  output  3, alu_result  input  32: shared ALU operands, op code (000 ADD, 001 SUB, 101 SLTU), ALU output.

Function
REQ-012 SHALL implement states IDLE, MUL, DCMP, DSUB, DONE.
REQ-013 IDLE/DONE with start=1 SHALL capture op/opa/opb, clear acc/rem/quotient, step counter=0, go to MUL (op[1]=0) or DCMP (op[1]=1).
REQ-014 busy SHALL be 1 in MUL, DCMP, DSUB only; start while busy=1 SHALL be ignored.
REQ-015 MUL: each cycle drive alu_a=acc, alu_b=mcand, alu_sel=000; if mplier[0]=1 acc<=alu_result; mcand<<=1, mplier>>=1; after 32 cycles go DONE with result=acc (product mod 2^32).
REQ-016 DCMP: form rem_shift={rem[30:0],dividend[31]}, rem_msb=rem[31]; drive alu_a=rem_shift, alu_b=divisor, alu_sel=101; qbit=rem_msb OR NOT alu_result[0]; go DSUB.
REQ-017 DSUB: drive alu_a=rem_shift, alu_b=divisor, alu_sel=001; rem<=qbit ? alu_result : rem_shift; quotient<=(quotient<<1)|qbit; dividend<<=1; after 32 DCMP/DSUB pairs go DONE, result=quotient (DIVU) or rem (REMU).
REQ-018 Latency SHALL be fixed: done asserted 33 cycles after the start edge for MUL, 65 for DIVU/REMU.
REQ-019 DONE SHALL last exactly one cycle, done=1, busy=0, then IDLE unless start=1.
REQ-020 Divide by zero SHALL need no special case: quotient=0xFFFFFFFF, remainder=opa, normal latency.
REQ-021 In IDLE/DONE alu_a=0, alu_b=0, alu_sel=000.
REQ-022 flush=1 SHALL return to IDLE next cycle, no done, result unchanged; flush has priority over start.

Reset
REQ-023 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, result=0, alu_a=0, alu_b=0, alu_sel=000, all internal registers 0.
REQ-024 Reset mid-operation SHALL discard the operation; no done after release.
REQ-025 First start SHALL be accepted on the first rising edge with rst_n=1.

Configuration
REQ-026 Macro ALU_SEQ_DIV_EN defined: DIVU/REMU per REQ-016..018.
REQ-027 Macro ALU_SEQ_DIV_EN undefined: DCMP/DSUB and divider registers absent; op[1]=1 goes directly to DONE next cycle with result=0 (latency 1); MUL unchanged.

Verification
REQ-028 MUL opa=7, opb=6 -> done at cycle 33, result=42, busy high cycles 1..32.
REQ-029 MUL opa=0xFFFFFFFF, opb=0xFFFFFFFF -> result=0x00000001.
REQ-030 DIVU 100/7 -> result=14 at cycle 65; REMU 100/7 -> result=2; alu_sel alternates 101/001.
REQ-031 DIVU 0x80000000/3 -> 0x2AAAAAAA; REMU 0xFFFFFFFF/0x80000001 -> 0x7FFFFFFE (rem_msb path); DIVU 0x1234/0 -> 0xFFFFFFFF, REMU -> 0x1234.
REQ-032 flush at cycle 10 of MUL -> IDLE cycle 11, no done, result keeps prior value; start in DONE cycle -> accepted, busy=1 next cycle.
REQ-033 rst_n low at cycle 20 of DIVU -> outputs zero immediately, no done after release; without ALU_SEQ_DIV_EN DIVU -> done cycle 1, result=0.
